// File: rtl/traffic_pkg.sv
// Shared types and constants for the actuated four-approach phase scheduler.
package traffic_pkg;

  localparam int unsigned NUM_DIR = 4;

  // Lamp codes are driven unchanged onto the intersection light outputs.
  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    PhAllRed = 2'b00,
    PhGreen  = 2'b01,
    PhYellow = 2'b10
  } phase_t;

endpackage

// File: rtl/traffic_phase_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational round-robin next-grant search over four approaches.
// Priority runs last+1, last+2, last+3, then last itself.
module rr_arbiter4
  import traffic_pkg::*;
(
  input  logic [1:0]         i_last,
  input  logic [NUM_DIR-1:0] i_req,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  logic [1:0] w_cand;

  // Walk from the lowest priority up so the highest-priority hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = i_last;
    w_cand  = i_last;
    for (int k = NUM_DIR; k >= 1; k--) begin
      w_cand = i_last + 2'(k);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven round-robin GREEN/YELLOW/ALL_RED scheduler.
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk11,
  input  logic       rst11,
  input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emg_req,
  input  logic [1:0] emg_dir,
`endif
  output logic [1:0] light0,
  output logic [1:0] light1,
  output logic [1:0] light2,
  output logic [1:0] light3,
  output logic [1:0] active_dir,
  output logic       grant_pulse
);

  localparam logic [CNT_W-1:0] L_GMIN   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] L_GMAX   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALLRED_T - 1);

  phase_t             r_state;
  phase_t             w_state_d;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_d;
  logic [1:0]         r_active;
  logic [1:0]         w_active_d;
  logic               r_pulse;
  logic               w_load;
  logic               w_timer_sat;

  logic               w_arb_valid;
  logic [1:0]         w_arb_idx;
  logic               w_other;
  logic               w_gap_out;
  logic               w_max_out;

  logic               w_preempt;
  logic               w_max_hold;
  logic               w_emg_grant;
  logic [1:0]         w_emg_dir;

  light_t             w_lights [NUM_DIR];

  rr_arbiter4 u_arb (
    .i_last  (r_active),
    .i_req   (req),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

`ifdef EMERGENCY_PREEMPT_EN
  // Preempt a green on any other approach; hold the emergency approach past max-out.
  assign w_preempt   = emg_req && (emg_dir != r_active);
  assign w_max_hold  = emg_req && (emg_dir == r_active);
  assign w_emg_grant = emg_req;
  assign w_emg_dir   = emg_dir;
`else
  assign w_preempt   = 1'b0;
  assign w_max_hold  = 1'b0;
  assign w_emg_grant = 1'b0;
  assign w_emg_dir   = 2'd0;
`endif

  // Demand from any approach other than the one holding right-of-way.
  assign w_other   = |(req & ~(4'b0001 << r_active));
  assign w_gap_out = w_other && (r_timer >= L_GMIN) && !req[r_active];
  assign w_max_out = w_other && (r_timer >= L_GMAX) && !w_max_hold;

  // State register: phase, timer, granted approach and grant pulse.
  always_ff @(posedge clk11) begin
    if (rst11) begin
      r_state  <= PhAllRed;
      r_timer  <= '0;
      r_active <= 2'd3;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_active <= w_active_d;
      r_pulse  <= w_load;
    end
  end

  // Next-state logic: phase transitions, grant selection and timer update.
  always_comb begin
    w_state_d   = r_state;
    w_active_d  = r_active;
    w_load      = 1'b0;
    w_timer_sat = 1'b0;
    unique case (r_state)
      PhAllRed: begin
        w_timer_sat = (r_timer >= L_ALLRED);
        if (r_timer >= L_ALLRED) begin
          if (w_emg_grant) begin
            w_state_d  = PhGreen;
            w_active_d = w_emg_dir;
            w_load     = 1'b1;
          end else if (w_arb_valid) begin
            w_state_d  = PhGreen;
            w_active_d = w_arb_idx;
            w_load     = 1'b1;
          end
        end
      end
      PhGreen: begin
        w_timer_sat = (r_timer >= L_GMAX);
        if (w_gap_out || w_max_out || w_preempt) w_state_d = PhYellow;
      end
      PhYellow: begin
        w_timer_sat = (r_timer >= L_YELLOW);
        if (r_timer >= L_YELLOW) w_state_d = PhAllRed;
      end
      default: w_state_d = PhAllRed;
    endcase
    // Saturating the timer in every phase keeps a long idle or rest from wrapping.
    if (w_state_d != r_state) begin
      w_timer_d = '0;
    end else if (w_timer_sat) begin
      w_timer_d = r_timer;
    end else begin
      w_timer_d = r_timer + 1'b1;
    end
  end

  // Output decode: Moore lamps from phase and granted approach.
  always_comb begin
    for (int d = 0; d < NUM_DIR; d++) begin
      w_lights[d] = RED;
    end
    if (r_state == PhGreen) begin
      w_lights[r_active] = GREEN;
    end else if (r_state == PhYellow) begin
      w_lights[r_active] = YELLOW;
    end
  end

  assign light0      = w_lights[0];
  assign light1      = w_lights[1];
  assign light2      = w_lights[2];
  assign light3      = w_lights[3];
  assign active_dir  = r_active;
  assign grant_pulse = r_pulse;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: a cycle model feeds a scoreboard
// queue, plus directed checks on phase lengths and grant order.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 4;
  localparam int GMAX = 12;
  localparam int YEL  = 2;
  localparam int ARED = 1;
  localparam int PH_G = 0;
  localparam int PH_Y = 1;
  localparam int PH_R = 2;

  logic       clk11;
  logic       rst11;
  logic [3:0] req;
  logic       emg_req;
  logic [1:0] emg_dir;
  logic [1:0] light0, light1, light2, light3;
  logic [1:0] active_dir;
  logic       grant_pulse;

  int n_total;
  int n_bad;

  int m_ph;
  int m_t;
  int m_dir;
  bit m_pulse;

  logic [10:0] exp_q [$];

  traffic_phase_scheduler #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YEL),
    .ALLRED_T  (ARED),
    .CNT_W     (8)
  ) dut (
    .clk11       (clk11),
    .rst11       (rst11),
    .req         (req),
`ifdef EMERGENCY_PREEMPT_EN
    .emg_req     (emg_req),
    .emg_dir     (emg_dir),
`endif
    .light0      (light0),
    .light1      (light1),
    .light2      (light2),
    .light3      (light3),
    .active_dir  (active_dir),
    .grant_pulse (grant_pulse)
  );

  initial clk11 = 1'b0;
  always #5 clk11 = ~clk11;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: what the DUT must show after the coming clock edge.
  task automatic model_step();
    bit found;
    bit other;
    bit go;
    int nxt;
    m_pulse = 1'b0;
    found   = 1'b0;
    nxt     = 0;
    if (rst11) begin
      m_ph  = PH_R;
      m_t   = 0;
      m_dir = 3;
      return;
    end
    case (m_ph)
      PH_R: begin
        if (m_t >= ARED - 1) begin
`ifdef EMERGENCY_PREEMPT_EN
          if (emg_req) begin
            found = 1'b1;
            nxt   = int'(emg_dir);
          end
`endif
          for (int k = 1; k <= 4; k++) begin
            if (!found && req[(m_dir + k) % 4]) begin
              found = 1'b1;
              nxt   = (m_dir + k) % 4;
            end
          end
        end
        if (found) begin
          m_ph    = PH_G;
          m_t     = 0;
          m_dir   = nxt;
          m_pulse = 1'b1;
        end else begin
          m_t++;
        end
      end
      PH_G: begin
        other = 1'b0;
        for (int d = 0; d < 4; d++) if (d != m_dir && req[d]) other = 1'b1;
        go = other && (m_t >= GMIN - 1) && !req[m_dir];
`ifdef EMERGENCY_PREEMPT_EN
        if (other && m_t >= GMAX - 1 && !(emg_req && int'(emg_dir) == m_dir)) go = 1'b1;
        if (emg_req && int'(emg_dir) != m_dir) go = 1'b1;
`else
        if (other && m_t >= GMAX - 1) go = 1'b1;
`endif
        if (go) begin
          m_ph = PH_Y;
          m_t  = 0;
        end else begin
          m_t++;
        end
      end
      default: begin
        if (m_t >= YEL - 1) begin
          m_ph = PH_R;
          m_t  = 0;
        end else begin
          m_t++;
        end
      end
    endcase
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] l [4];
    for (int d = 0; d < 4; d++) begin
      l[d] = 2'b00;
      if (d == m_dir && m_ph == PH_G) l[d] = 2'b10;
      if (d == m_dir && m_ph == PH_Y) l[d] = 2'b01;
    end
    return {l[3], l[2], l[1], l[0], 2'(m_dir), m_pulse};
  endfunction

  // One clock: predict, push, clock, pop and compare.
  task automatic tick();
    logic [10:0] exp_v;
    int nonred;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clk11);
    #1;
    if (exp_q.size() == 0) begin
      check_value("sb_empty", 32'd0, 32'd1);
    end else begin
      exp_v = exp_q.pop_front();
      check_value("cycle", {21'd0, light3, light2, light1, light0, active_dir, grant_pulse},
                  {21'd0, exp_v});
    end
    nonred = (light0 != 2'b00) + (light1 != 2'b00) + (light2 != 2'b00) + (light3 != 2'b00);
    check_value("one_nonred", 32'(nonred <= 1), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst11 = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst11 = 1'b0;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int grants [$];
    int waited;
    n_total = 0;
    n_bad   = 0;
    m_ph    = PH_R;
    m_t     = 0;
    m_dir   = 3;
    m_pulse = 1'b0;
    rst11   = 1'b1;
    req     = 4'b0000;
    emg_req = 1'b0;
    emg_dir = 2'd0;

    // Idle with no demand: all red, no grants.
    do_reset(3);
    check_value("reset_dir", 32'(active_dir), 32'd3);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant_pulse) cnt_a++;
    end
    check_value("idle_pulses", 32'(cnt_a), 32'd0);
    check_value("idle_lights", {24'd0, light3, light2, light1, light0}, 32'd0);

    // Single demand: green one cycle after release, held indefinitely.
    req = 4'b0001;
    do_reset(2);
    tick();
    check_value("first_green", 32'(light0), 32'd2);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (light0 == 2'b01) cnt_a++;
      if (grant_pulse) cnt_b++;
    end
    check_value("rest_no_yellow", 32'(cnt_a), 32'd0);
    check_value("rest_no_regrant", 32'(cnt_b), 32'd0);

    // Max-out between approaches 0 and 2.
    req = 4'b0101;
    do_reset(2);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (light0 == 2'b10) cnt_a++;
      if (light0 == 2'b01) cnt_b++;
      if (light2 == 2'b10 && cnt_c == 0) cnt_c = i;
    end
    check_value("maxout_green_len", 32'(cnt_a), 32'd12);
    check_value("maxout_yellow_len", 32'(cnt_b), 32'd2);
    check_value("maxout_next_green", 32'(cnt_c), 32'd16);

    // Gap-out after the minimum: drop req1 at timer 6.
    req = 4'b1010;
    do_reset(2);
    tick();
    check_value("gap_grant1", 32'(light1), 32'd2);
    for (int i = 0; i < 6; i++) tick();
    req = 4'b1000;
    tick();
    check_value("gap_yellow", 32'(light1), 32'd1);
    for (int i = 0; i < 6; i++) tick();

    // Gap before the minimum: drop req1 at timer 1, green lasts GREEN_MIN cycles.
    req = 4'b1010;
    do_reset(2);
    cnt_a = 0;
    tick();
    if (light1 == 2'b10) cnt_a++;
    tick();
    if (light1 == 2'b10) cnt_a++;
    req = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (light1 == 2'b10) cnt_a++;
    end
    check_value("min_green_len", 32'(cnt_a), 32'(GMIN));

    // Full demand: rotation 0,1,2,3,0.
    req = 4'b1111;
    do_reset(2);
    for (int i = 0; i < 65; i++) begin
      tick();
      if (grant_pulse) grants.push_back(int'(active_dir));
    end
    check_value("rr_count", 32'(grants.size() >= 5), 32'd1);
    if (grants.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_value("rr_order", 32'(grants[i]), 32'(i % 4));
    end

    // Reset in the middle of a yellow.
    waited = 0;
    while (!(light0 == 2'b01 || light1 == 2'b01 || light2 == 2'b01 || light3 == 2'b01)
           && waited < 40) begin
      tick();
      waited++;
    end
    check_value("yellow_seen", 32'(waited < 40), 32'd1);
    rst11 = 1'b1;
    tick();
    rst11 = 1'b0;
    check_value("rst_mid_lights", {24'd0, light3, light2, light1, light0}, 32'd0);
    check_value("rst_mid_dir", 32'(active_dir), 32'd3);

`ifdef EMERGENCY_PREEMPT_EN
    // Preempt road0 at timer 1 toward road2, then hold road2 past max-out.
    req = 4'b0101;
    do_reset(2);
    tick();
    tick();
    emg_req = 1'b1;
    emg_dir = 2'd2;
    tick();
    check_value("emg_yellow", 32'(light0), 32'd1);
    tick();
    tick();
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (light2 == 2'b10) cnt_a++;
    end
    check_value("emg_hold_green", 32'(cnt_a), 32'd20);
    emg_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`endif

    check_value("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
